switch_output_queue: RTL
========================

Name: switch_output_queue

Overview:
- Per-output-port egress buffer placed directly downstream of very_simple_switch; one instance per switch output.
- Captures the switch's per-port data_out_valid / data_out flow into a FIFO.
- Re-presents that data to the consumer with a valid/ready handshake.
- The switch has no backpressure, so overflow is detected, dropped and flagged here.

Parameters:
- DATA_WIDTH, 64, width of one data word (matches the switch).
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- AFULL_LEVEL, 6, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  one bit of switch data_out_valid.
- in_data  input  DATA_WIDTH  matching slice of switch data_out.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  DATA_WIDTH  head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL_LEVEL.
- overflow  output  1  registered one-cycle pulse: word dropped last cycle.

Behaviour:
- Reset:
  - Sampled only on the rising clk edge while reset==0.
  - Clears wr_ptr, rd_ptr, count, overflow; out_valid=0, almost_full=0.
  - Memory contents are not reset; out_data is don't-care while out_valid=0.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. Full/empty are derived from count, not from pointer compare.
- Pop: pop = out_valid && out_ready. On pop, rd_ptr increments. out_ready while empty is ignored.
- Push:
  - push = in_valid && (count < DEPTH || pop).
  - Writing while full is allowed when a pop happens in the same cycle.
  - On push: mem[wr_ptr] <= in_data, wr_ptr increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged.
  - Count never exceeds DEPTH or goes below 0.
- Drop: in_valid && count==DEPTH && !pop. The word is discarded, no state changes except overflow, which reads 1 in the next cycle only. Consecutive drops give a multi-cycle overflow high, one cycle per dropped word.
- First-word fall-through:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], combinational read of registered storage.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N, so the consumer can take it at edge N+1. Empty-queue simultaneous in/out is not a bypass; the pushed word appears one cycle later.
- Flags: almost_full and out_valid are combinational from registered count, so both are glitch-free per cycle.
- Ordering: strict FIFO. No reordering, no duplication.
- Reset mid-operation: all queued words are discarded. in_valid during reset is ignored, and no overflow pulse is generated.

Optional Feature:
- Macro: SWITCH_OUTQ_DROP_COUNTER_EN.
- Defined:
  - Adds output drop_count, 16 bits, reset to 0.
  - Increments on every dropped word and saturates at 16'hFFFF (no wrap).
  - Adds input drop_count_clear, 1 bit; when high, next value is 0. Clear has priority over a simultaneous increment.
- Undefined: neither port exists, and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with in_valid=1, then release -> count=0, out_valid=0, overflow=0 throughout reset and the first cycle after.
- Fill then drain (DEPTH=8, out_ready=0):
  - Push in_data 0..7 on consecutive cycles -> count reaches 8.
  - almost_full asserts once count=6.
  - Then out_ready=1 for 8 cycles -> out_data sequence 0,1,...,7, count returns to 0, out_valid drops after the last pop.
- Overflow: queue full, out_ready=0, present in_data=64'hDEAD for 2 cycles -> overflow=1 for exactly 2 cycles, count stays 8, and 0xDEAD never appears on out_data. With the macro defined, drop_count=2.
- Full with simultaneous push and pop: queue full of 0..7, in_data=100 with out_ready=1 -> out_data 0 accepted, 100 stored, count stays 8, overflow=0. A later drain ends ...,7,100.
- Pointer wrap: continuous push and pop for 20 cycles with in_data=i -> out_data equals i one cycle later, count oscillates within 0..1, no loss across wr_ptr/rd_ptr wrap.
- Reset mid-operation: count=5, assert reset for 1 cycle -> count=0 and out_valid=0 next cycle; the next push of 64'h55 is the first word out.

Source files
------------

// File: rtl/switch_output_queue_if.sv
// Handshake bundle between the switch-side producer, the egress queue and its consumer.
// Optional drop counter signals exist only when SWITCH_OUTQ_DROP_COUNTER_EN is defined.
interface switch_output_queue_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
);
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     almost_full;
  logic                     overflow;
`ifdef SWITCH_OUTQ_DROP_COUNTER_EN
  logic [15:0]              drop_count;
  logic                     drop_count_clear;

  modport master (
    output in_valid, in_data, out_ready, drop_count_clear,
    input  out_valid, out_data, count, almost_full, overflow, drop_count
  );
  modport slave (
    input  in_valid, in_data, out_ready, drop_count_clear,
    output out_valid, out_data, count, almost_full, overflow, drop_count
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, count, almost_full, overflow
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, count, almost_full, overflow
  );
`endif
endinterface

// File: rtl/switch_output_queue.sv
// Per-port egress FIFO behind very_simple_switch: first-word fall-through, drop-on-full with overflow pulse.
// Define SWITCH_OUTQ_DROP_COUNTER_EN to add a saturating 16-bit drop counter with clear.
module switch_output_queue #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input logic                   clk,
  input logic                   reset,
  switch_output_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_COUNT = CW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;

  logic full, pop, push, drop;

  // Full/empty come from the occupancy count so the pointers can wrap freely.
  assign full = (count == FULL_COUNT);
  assign pop  = (count != '0) && q.out_ready;
  assign push = q.in_valid && (!full || pop);
  assign drop = q.in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // NOTE: storage has no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && reset) mem[wr_ptr] <= q.in_data;
  end

  assign q.out_valid   = (count != '0);
  assign q.out_data    = mem[rd_ptr];
  assign q.count       = count;
  assign q.almost_full = (count >= AFULL_COUNT);
  assign q.overflow    = overflow;

`ifdef SWITCH_OUTQ_DROP_COUNTER_EN
  logic [15:0] drop_count;

  // Clear wins over a simultaneous drop; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (q.drop_count_clear) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign q.drop_count = drop_count;
`endif
endmodule
